rotor_stepper: RTL and testbench
================================

ROTOR_STEPPER -- requirements
Module: rotor_stepper

Interface
REQ-001 SHALL have parameter MOD, default 26, meaning the rotor position modulus; positions are 0..MOD-1.
REQ-002 SHALL have parameter NOTCH_R, default 21, meaning the right-rotor position that causes a middle-rotor step.
REQ-003 SHALL have parameter NOTCH_M, default 4, meaning the middle-rotor position that causes a left-rotor step.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port load  input  1  request to load the initial rotor positions.
REQ-007 SHALL have port load_pos  input  24  initial positions: [23:16] left, [15:8] middle, [7:0] right.
REQ-008 SHALL have port key_valid  input  1  keypress request; the rotors step once per accepted key.
REQ-009 SHALL have port key_ready  output  1  high when a key or load can be accepted.
REQ-010 SHALL have port pos_l, pos_m, pos_r  output  8 each  current rotor positions.
REQ-011 SHALL have port step_done  output  1  one-cycle pulse when the new positions are valid.

Function
REQ-012 SHALL implement an FSM with states IDLE, STEP and DONE.
REQ-013 IDLE SHALL assert key_ready; STEP and DONE SHALL deassert it.
REQ-014 In IDLE, when load=1, the block SHALL register load_pos next cycle and stay in IDLE. Load has priority over a simultaneous key_valid, which is not accepted.
REQ-015 On load, any field with value >= MOD SHALL be stored as 0.
REQ-016 In IDLE, when key_valid=1 and load=0, the key SHALL be accepted and the FSM SHALL go to STEP.
REQ-017 In STEP, the block SHALL compute the next positions from the pre-step values only, then update them and go to DONE.
  - Right: always steps.
  - Middle: steps if pos_r==NOTCH_R, or if the double-step condition holds (REQ-027).
  - Left: steps if pos_m==NOTCH_M and the middle is stepping because of its own notch (REQ-027).
REQ-018 Each step SHALL be an increment modulo MOD: MOD-1 SHALL wrap to 0, and no out-of-range value is ever stored.
REQ-019 The increment SHALL use 8-bit unsigned arithmetic. The carry-out of bit 7 is discarded and the wrap compare is against MOD-1.
REQ-020 In DONE, step_done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-021 Latency SHALL be exactly 2 cycles from key acceptance to step_done, with the new positions visible on pos_* from the DONE cycle onward.
REQ-022 load and key_valid SHALL be ignored in STEP and DONE. No request is queued.
REQ-023 Back-to-back keys held high SHALL be accepted one per 3 cycles.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE, pos_l=pos_m=pos_r=0, step_done=0 and key_ready=0.
REQ-025 After rst is released, key_ready SHALL be 1 in the first cycle.
REQ-026 Reset asserted in STEP or DONE SHALL abort the step with no partial update retained and no step_done pulse.

Configuration
REQ-027 Macro DOUBLE_STEP_EN SHALL select the stepping rule.
  - Defined: when pos_m==NOTCH_M, both the middle and left rotors SHALL step on that key, whatever the right-rotor position (Enigma double step).
  - Undefined: the block SHALL use pure odometer carry. The middle steps only when the right wraps past NOTCH_R, and the left steps only when the middle steps from NOTCH_M.

Verification
REQ-028 rst pulse mid-STEP -> positions 0,0,0; no step_done; key_ready=1 in the first cycle after release.
REQ-029 Load (0,3,20), then 3 keys with DOUBLE_STEP_EN defined -> pos_l/pos_m/pos_r go 0,3,21 -> 0,4,22 -> 1,5,23.
REQ-030 Same as REQ-029 with DOUBLE_STEP_EN undefined -> 0,3,21 -> 0,4,22 -> 0,4,23.
REQ-031 Load (25,25,25) with NOTCH_R=25, NOTCH_M=25, then 1 key -> 0,0,0 (wrap on all three rotors).
REQ-032 load=1 and key_valid=1 in the same IDLE cycle with load_pos=(30,2,7) -> stored as 0,2,7; no step_done.
REQ-033 key_valid held high for 9 cycles from IDLE -> exactly 3 step_done pulses, 3 cycles apart; pos_r advances by 3.

Source files
------------

// File: rtl/rotor_stepper.sv
// Three-rotor stepping controller: load initial positions, then advance the rotors once per accepted key.
// Build option DOUBLE_STEP_EN selects the Enigma double-step rule; without it the rotors carry like an odometer.
//
// state | meaning
// IDLE  | ready for a load or a key
// STEP  | next positions computed from the pre-step values and written
// DONE  | step_done pulse, back to IDLE on the next edge
module rotor_stepper #(
  parameter int MOD     = 26,
  parameter int NOTCH_R = 21,
  parameter int NOTCH_M = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_pos,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [7:0]  pos_l,
  output logic [7:0]  pos_m,
  output logic [7:0]  pos_r,
  output logic        step_done
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam logic [7:0] LAST = 8'(MOD - 1);
  localparam logic [7:0] NR   = 8'(NOTCH_R);
  localparam logic [7:0] NM   = 8'(NOTCH_M);

  state_t state;
  logic   ready_q;
  logic   step_m;
  logic   step_l;

  function automatic logic [7:0] inc(input logic [7:0] p);
    return (p == LAST) ? 8'd0 : p + 8'd1;
  endfunction

  function automatic logic [7:0] sanitize(input logic [7:0] p);
    return ({24'd0, p} >= 32'(MOD)) ? 8'd0 : p;
  endfunction

`ifdef DOUBLE_STEP_EN
  // A middle rotor sitting on its notch drags itself and the left rotor along.
  assign step_m = (pos_r == NR) || (pos_m == NM);
  assign step_l = (pos_m == NM);
`else
  assign step_m = (pos_r == NR);
  assign step_l = step_m && (pos_m == NM);
`endif

  // ready_q comes out of reset high, but the port must read low while rst is held.
  assign key_ready = ready_q & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      pos_l     <= 8'd0;
      pos_m     <= 8'd0;
      pos_r     <= 8'd0;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            pos_l <= sanitize(load_pos[23:16]);
            pos_m <= sanitize(load_pos[15:8]);
            pos_r <= sanitize(load_pos[7:0]);
          end else if (key_valid) begin
            state   <= STEP;
            ready_q <= 1'b0;
          end
        end
        STEP: begin
          pos_r     <= inc(pos_r);
          if (step_m) pos_m <= inc(pos_m);
          if (step_l) pos_l <= inc(pos_l);
          step_done <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotor_stepper.sv
// Scoreboard bench for rotor_stepper: a cycle-level reference model feeds an expectation queue
// that a separate monitor drains on every step_done pulse.
module tb_rotor_stepper;

  localparam int MODV = 26;
  localparam int NRV  = 21;
  localparam int NMV  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        key_valid = 1'b0;
  logic [23:0] load_pos = 24'd0;
  logic        key_ready, step_done;
  logic [7:0]  pos_l, pos_m, pos_r;

  logic        load2 = 1'b0;
  logic        key_valid2 = 1'b0;
  logic [23:0] load_pos2 = 24'd0;
  logic        key_ready2, step_done2;
  logic [7:0]  pos_l2, pos_m2, pos_r2;

  rotor_stepper #(.MOD(MODV), .NOTCH_R(NRV), .NOTCH_M(NMV)) dut (
    .clk(clk), .rst(rst), .load(load), .load_pos(load_pos), .key_valid(key_valid),
    .key_ready(key_ready), .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .step_done(step_done)
  );

  rotor_stepper #(.MOD(26), .NOTCH_R(25), .NOTCH_M(25)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .load_pos(load_pos2), .key_valid(key_valid2),
    .key_ready(key_ready2), .pos_l(pos_l2), .pos_m(pos_m2), .pos_r(pos_r2), .step_done(step_done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int l;
    int m;
    int r;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  // Reference model state: visible positions, pending updates and busy countdown.
  int cur_l = 0, cur_m = 0, cur_r = 0;
  int nxt_l, nxt_m, nxt_r;
  int ld_l, ld_m, ld_r;
  bit ld_pend = 0;
  int busy = 0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk3(input string name, input int l, input int m, input int r);
    chk({name, "_l"}, int'(pos_l), l);
    chk({name, "_m"}, int'(pos_m), m);
    chk({name, "_r"}, int'(pos_r), r);
  endtask

  function automatic int clampf(input int f, input int modv);
    return (f >= modv) ? 0 : f;
  endfunction

  // Stepping rule stated directly: right always moves, middle on right notch (or its own notch with
  // double stepping), left when the middle leaves its notch.
  task automatic model_step(input int l, input int m, input int r, input int nr, input int nm,
                            input int modv, output int ol, output int om, output int orr);
    bit mv_m, mv_l;
`ifdef DOUBLE_STEP_EN
    mv_m = (r == nr) || (m == nm);
    mv_l = (m == nm);
`else
    mv_m = (r == nr);
    mv_l = mv_m && (m == nm);
`endif
    orr = (r + 1) % modv;
    om  = mv_m ? (m + 1) % modv : m;
    ol  = mv_l ? (l + 1) % modv : l;
  endtask

  task automatic drive(input logic ld, input logic [23:0] lp, input logic kv);
    @(negedge clk);
    if (ld_pend) begin
      cur_l = ld_l; cur_m = ld_m; cur_r = ld_r;
      ld_pend = 0;
    end
    if (busy > 0) begin
      busy--;
      if (busy == 1) begin
        cur_l = nxt_l; cur_m = nxt_m; cur_r = nxt_r;
      end
    end
    chk3("pos", cur_l, cur_m, cur_r);
    chk("key_ready", int'(key_ready), (busy == 0) ? 1 : 0);
    load = ld; load_pos = lp; key_valid = kv;
    if (busy == 0) begin
      if (ld) begin
        ld_l = clampf(int'(lp[23:16]), MODV);
        ld_m = clampf(int'(lp[15:8]), MODV);
        ld_r = clampf(int'(lp[7:0]), MODV);
        ld_pend = 1;
      end else if (kv) begin
        model_step(cur_l, cur_m, cur_r, NRV, NMV, MODV, nxt_l, nxt_m, nxt_r);
        exp_q.push_back('{l: nxt_l, m: nxt_m, r: nxt_r, cyc: cyc + 2});
        busy = 3;
      end
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1; load = 1'b0; key_valid = 1'b0;
    exp_q.delete();
    busy = 0; ld_pend = 0;
    cur_l = 0; cur_m = 0; cur_r = 0;
    #1;
    chk3("rst_pos", 0, 0, 0);
    chk("rst_key_ready", int'(key_ready), 0);
    chk("rst_step_done", int'(step_done), 0);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("key_ready_after_rst", int'(key_ready), 1);
    chk3("pos_after_rst", 0, 0, 0);
  endtask

  task automatic key_once();
    drive(1'b0, 24'd0, 1'b1);
    drive(1'b0, 24'd0, 1'b0);
    drive(1'b0, 24'd0, 1'b0);
  endtask

  // Monitor: pop and compare on every pulse, flag pulses that are late, missing or unexpected.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("step_done_in_rst", int'(step_done), 0);
      end else if (step_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_step_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk3("done_pos", e.l, e.m, e.r);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missing_step_done", 0, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int before_r, before_cnt, r;
    logic [7:0] fl, fm, fr;
    bit got;

    repeat (3) @(negedge clk);
    #1;
    chk3("init_rst_pos", 0, 0, 0);
    chk("init_rst_key_ready", int'(key_ready), 0);
    chk("init_rst_step_done", int'(step_done), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_key_ready", int'(key_ready), 1);

    // Notch walk from (0,3,20).
    drive(1'b1, {8'd0, 8'd3, 8'd20}, 1'b0);
    key_once();
    chk3("walk1", 0, 3, 21);
    key_once();
    chk3("walk2", 0, 4, 22);
    key_once();
`ifdef DOUBLE_STEP_EN
    chk3("walk3", 1, 5, 23);
`else
    chk3("walk3", 0, 4, 23);
`endif

    // Load beats a simultaneous key; out-of-range field clears.
    drive(1'b1, {8'd30, 8'd2, 8'd7}, 1'b1);
    drive(1'b0, 24'd0, 1'b0);
    chk3("load_priority", 0, 2, 7);
    drive(1'b0, 24'd0, 1'b0);
    drive(1'b0, 24'd0, 1'b0);

    // Key held for 9 cycles: one acceptance every 3 cycles.
    before_r   = int'(pos_r);
    before_cnt = done_cnt;
    repeat (9) drive(1'b0, 24'd0, 1'b1);
    repeat (3) drive(1'b0, 24'd0, 1'b0);
    chk("held_key_pulses", done_cnt - before_cnt, 3);
    chk("held_key_pos_r", int'(pos_r), (before_r + 3) % MODV);

    // Reset in the middle of a step.
    drive(1'b1, {8'd5, 8'd6, 8'd7}, 1'b0);
    drive(1'b0, 24'd0, 1'b1);
    do_reset(2);
    before_cnt = done_cnt;
    repeat (3) drive(1'b0, 24'd0, 1'b0);
    chk("abort_no_pulse", done_cnt - before_cnt, 0);
    chk3("abort_pos", 0, 0, 0);

    // Full wrap on all three rotors, notches at the top position.
    drive(1'b0, 24'd0, 1'b0);
    load2 = 1'b1; load_pos2 = {8'd25, 8'd25, 8'd25};
    drive(1'b0, 24'd0, 1'b0);
    load2 = 1'b0; key_valid2 = 1'b1;
    chk("wrap_loaded_l", int'(pos_l2), 25);
    chk("wrap_loaded_r", int'(pos_r2), 25);
    drive(1'b0, 24'd0, 1'b0);
    key_valid2 = 1'b0;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk);
      #1;
      if (step_done2) got = 1;
    end
    chk("wrap_step_done", int'(got), 1);
    chk("wrap_l", int'(pos_l2), 0);
    chk("wrap_m", int'(pos_m2), 0);
    chk("wrap_r", int'(pos_r2), 0);

    // Randomized traffic, loads biased onto the notch positions.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset($urandom_range(1, 3));
      end else begin
        fl = 8'($urandom_range(0, 30));
        fm = ($urandom_range(0, 2) == 0) ? 8'(NMV) : 8'($urandom_range(0, 30));
        fr = ($urandom_range(0, 2) == 0) ? 8'(NRV - $urandom_range(0, 2)) : 8'($urandom_range(0, 30));
        drive(r < 12, {fl, fm, fr}, r < 75);
      end
    end
    repeat (5) drive(1'b0, 24'd0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
